// File: rtl/multicore_pkg.sv
// rtl/multicore_pkg.sv - shared widths, request code and sample type for the multicore array
package multicore_pkg;

    localparam int DATA_W     = 19;
    localparam int REQ_W      = 4;
    localparam int N_CORES    = 30;
    localparam int FIFO_DEPTH = 8;

    localparam logic [3:0] REQ_NONE = 4'd0;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/sample_dispatcher_if.sv
// rtl/sample_dispatcher_if.sv - upstream sample stream, per-core request bus and shared sample bus
interface sample_dispatcher_if #(
    parameter int DATA_W  = 19,
    parameter int REQ_W   = 4,
    parameter int N_CORES = 30,
    parameter int DEPTH   = 8
);

    logic signed [DATA_W-1:0]      s_data;
    logic                          s_valid;
    logic                          s_ready;
    logic [N_CORES*REQ_W-1:0]      req_in;
    logic signed [DATA_W-1:0]      in;
    logic                          in_valid;
    logic [$clog2(DEPTH):0]        fifo_count;

    // master: upstream producer plus the core array; slave: the dispatcher
    modport master (
        output s_data, s_valid, req_in,
        input  s_ready, in, in_valid, fifo_count
    );

    modport slave (
        input  s_data, s_valid, req_in,
        output s_ready, in, in_valid, fifo_count
    );

endinterface

// File: rtl/sample_dispatcher_fifo.sv
// rtl/sample_dispatcher_fifo.sv - synchronous sample FIFO with extra-bit pointers
module sample_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 19,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_pop,
    output logic signed [DATA_W-1:0] o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [AW:0]              o_count
);

    logic [AW:0]              r_wr_ptr;
    logic [AW:0]              r_rd_ptr;
    logic signed [DATA_W-1:0] r_mem [DEPTH];
    logic                     w_do_push;
    logic                     w_do_pop;

    // pointers carry one bit beyond the index so full and empty differ only in the MSB
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/sample_dispatcher.sv
// rtl/sample_dispatcher.sv - serves buffered samples onto the shared core bus on request
module sample_dispatcher #(
    parameter int N_CORES = multicore_pkg::N_CORES,
    parameter int REQ_W   = multicore_pkg::REQ_W,
    parameter int DATA_W  = multicore_pkg::DATA_W,
    parameter int DEPTH   = multicore_pkg::FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    sample_dispatcher_if.slave  bus,
    input  logic                clr,
    output logic                underrun,
    output logic [15:0]         underrun_cnt,
    output logic [31:0]         served_cnt
);

    import multicore_pkg::*;

    logic                     w_req_any;
    logic                     w_full;
    logic                     w_empty;
    logic signed [DATA_W-1:0] w_head;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_consume;
    logic                     w_starved;
    logic                     w_prime;
    logic                     w_pop;

    logic signed [DATA_W-1:0] r_in;
    logic                     r_in_valid;
    logic                     r_underrun;
    logic [15:0]              r_underrun_cnt;
    logic [31:0]              r_served_cnt;

    // several cores asking in the same cycle still take a single sample
    always_comb begin
        w_req_any = 1'b0;
        for (int k = 0; k < N_CORES; k++) begin
            if (bus.req_in[k*REQ_W +: REQ_W] != REQ_W'(REQ_NONE)) w_req_any = 1'b1;
        end
    end

    assign w_consume = w_req_any && r_in_valid;
    assign w_starved = w_req_any && !r_in_valid;
    assign w_prime   = !w_req_any && !r_in_valid && !w_empty;
    assign w_pop     = (w_consume && !w_empty) || w_prime;

    sample_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.s_valid),
        .i_data  (bus.s_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in       <= '0;
            r_in_valid <= 1'b0;
        end else begin
            if (w_pop) r_in <= w_head;
            if (w_consume && w_empty) r_in_valid <= 1'b0;
            else if (w_prime)         r_in_valid <= 1'b1;
        end
    end

    // clr outranks any same-cycle serve or underrun event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
            r_served_cnt   <= '0;
        end else if (clr) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
            r_served_cnt   <= '0;
        end else begin
            if (w_consume) r_served_cnt <= r_served_cnt + 32'd1;
            if (w_starved) begin
                r_underrun <= 1'b1;
                if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end
    end

    assign bus.s_ready    = !w_full;
    assign bus.in         = r_in;
    assign bus.in_valid   = r_in_valid;
    assign bus.fifo_count = w_count;
    assign underrun       = r_underrun;
    assign underrun_cnt   = r_underrun_cnt;
    assign served_cnt     = r_served_cnt;

endmodule

// File: tb/tb_sample_dispatcher.sv
// tb/tb_sample_dispatcher.sv - randomized and directed bench for sample_dispatcher against a queue model
module tb_sample_dispatcher;
    import multicore_pkg::*;

    localparam int DEPTH_T = 8;
    localparam int RW      = N_CORES*REQ_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic [31:0] served_cnt;

    int n_vec = 0;
    int n_err = 0;

    sample_t     q[$];
    sample_t     m_in;
    logic        m_valid;
    logic        m_und;
    logic [15:0] m_ucnt;
    logic [31:0] m_served;

    always #5 clk = ~clk;

    sample_dispatcher_if #(.DATA_W(DATA_W), .REQ_W(REQ_W), .N_CORES(N_CORES), .DEPTH(DEPTH_T)) bus ();

    sample_dispatcher #(
        .N_CORES (N_CORES),
        .REQ_W   (REQ_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH_T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .clr          (clr),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .served_cnt   (served_cnt)
    );

    function automatic logic [RW-1:0] core_req(input int k, input logic [REQ_W-1:0] code);
        logic [RW-1:0] r;
        r = '0;
        r[k*REQ_W +: REQ_W] = code;
        return r;
    endfunction

    function automatic logic any_request(input logic [RW-1:0] r);
        for (int k = 0; k < N_CORES; k++)
            if (r[k*REQ_W +: REQ_W] != '0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_in = '0; m_valid = 1'b0; m_und = 1'b0; m_ucnt = '0; m_served = '0;
    endtask

    // one clock: drive inputs, advance the behavioural model, land 1 time unit past the edge
    task automatic step(input logic v, input sample_t d, input logic [RW-1:0] r, input logic c);
        logic push;
        logic req;
        bus.s_valid = v; bus.s_data = d; bus.req_in = r; clr = c;
        req  = any_request(r);
        push = v && (q.size() < DEPTH_T);
        if (req && m_valid) begin
            m_served = m_served + 1;
            if (q.size() > 0) m_in = q.pop_front();
            else m_valid = 1'b0;
        end else if (req) begin
            m_und = 1'b1;
            if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 1;
        end else if (!m_valid && q.size() > 0) begin
            m_in = q.pop_front();
            m_valid = 1'b1;
        end
        if (push) q.push_back(d);
        if (c) begin m_und = 1'b0; m_ucnt = '0; m_served = '0; end
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.req_in = '0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL reset_in_valid: got %0b want 0", bus.in_valid); end
        n_vec++; if (bus.in !== sample_t'(0)) begin n_err++; $display("FAIL reset_in: got %0d want 0", bus.in); end
        n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %0b want 1", bus.s_ready); end
        n_vec++; if ({underrun, underrun_cnt, served_cnt} !== 49'd0) begin
            n_err++; $display("FAIL reset_counters: got und=%0b uc=%0d sc=%0d want 0", underrun, underrun_cnt, served_cnt);
        end
        n_vec++; if (bus.fifo_count !== '0) begin n_err++; $display("FAIL reset_fifo_count: got %0d want 0", bus.fifo_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_prime();
        step(1'b1, sample_t'(5), '0, 1'b0);
        n_vec++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL prime_early: in_valid got %0b want 0", bus.in_valid); end
        step(1'b1, sample_t'(-7), '0, 1'b0);
        n_vec++; if ({bus.in_valid, bus.in} !== {1'b1, sample_t'(5)}) begin
            n_err++; $display("FAIL prime_latency: got v=%0b in=%0d want v=1 in=5", bus.in_valid, bus.in);
        end
        step(1'b1, sample_t'(100), '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        n_vec++; if (bus.fifo_count !== 4'd2) begin n_err++; $display("FAIL prime_count: got %0d want 2", bus.fifo_count); end
        n_vec++; if (bus.in !== sample_t'(5)) begin n_err++; $display("FAIL prime_hold: got %0d want 5", bus.in); end
    endtask

    task automatic test_requests();
        step(1'b0, '0, core_req(0, 4'd1), 1'b0);
        n_vec++; if (bus.in !== sample_t'(-7)) begin n_err++; $display("FAIL req_core0: got %0d want -7", bus.in); end
        step(1'b0, '0, core_req(29, 4'h8), 1'b0);
        n_vec++; if (bus.in !== sample_t'(100)) begin n_err++; $display("FAIL req_core29: got %0d want 100", bus.in); end
        step(1'b0, '0, core_req(3, 4'd2) | core_req(17, 4'd5), 1'b0);
        n_vec++; if ({bus.in_valid, bus.in} !== {1'b0, sample_t'(100)}) begin
            n_err++; $display("FAIL req_multi: got v=%0b in=%0d want v=0 in=100", bus.in_valid, bus.in);
        end
        n_vec++; if (served_cnt !== 32'd3) begin n_err++; $display("FAIL req_served: got %0d want 3", served_cnt); end
    endtask

    task automatic test_underrun();
        step(1'b0, '0, core_req(5, 4'd3), 1'b0);
        n_vec++; if ({underrun, underrun_cnt} !== {1'b1, 16'd1}) begin
            n_err++; $display("FAIL underrun_flag: got und=%0b cnt=%0d want 1/1", underrun, underrun_cnt);
        end
        step(1'b1, sample_t'(42), '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        n_vec++; if ({bus.in_valid, bus.in, served_cnt} !== {1'b1, sample_t'(42), 32'd3}) begin
            n_err++; $display("FAIL underrun_prime: got v=%0b in=%0d sc=%0d want v=1 in=42 sc=3", bus.in_valid, bus.in, served_cnt);
        end
    endtask

    task automatic test_full();
        step(1'b0, '0, core_req(1, 4'd1), 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, sample_t'(200 + k - 1), '0, 1'b0);
            n_vec++; if (bus.s_ready !== (k < 9)) begin
                n_err++; $display("FAIL full_ready push%0d: got %0b want %0b", k, bus.s_ready, (k < 9));
            end
        end
        step(1'b1, sample_t'(999), '0, 1'b0);
        n_vec++; if ({bus.s_ready, bus.fifo_count, bus.in} !== {1'b0, 4'd8, sample_t'(200)}) begin
            n_err++; $display("FAIL full_block: got rdy=%0b cnt=%0d in=%0d want 0/8/200", bus.s_ready, bus.fifo_count, bus.in);
        end
        step(1'b0, '0, core_req(7, 4'd9), 1'b0);
        n_vec++; if ({bus.s_ready, bus.in} !== {1'b1, sample_t'(201)}) begin
            n_err++; $display("FAIL full_release: got rdy=%0b in=%0d want 1/201", bus.s_ready, bus.in);
        end
    endtask

    task automatic test_clr();
        step(1'b0, '0, core_req(12, 4'd4), 1'b1);
        n_vec++; if ({underrun, underrun_cnt, served_cnt, bus.in} !== {1'b0, 16'd0, 32'd0, sample_t'(202)}) begin
            n_err++; $display("FAIL clr_wins: got und=%0b uc=%0d sc=%0d in=%0d want 0/0/0/202", underrun, underrun_cnt, served_cnt, bus.in);
        end
        step(1'b0, '0, core_req(2, 4'd1), 1'b0);
        step(1'b0, '0, '0, 1'b1);
        n_vec++; if ({served_cnt, bus.in, bus.in_valid, bus.fifo_count} !== {32'd0, sample_t'(203), 1'b1, 4'd5}) begin
            n_err++; $display("FAIL clr_only_counters: got sc=%0d in=%0d v=%0b cnt=%0d want 0/203/1/5", served_cnt, bus.in, bus.in_valid, bus.fifo_count);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, sample_t'($urandom), (i % 2 == 1) ? core_req(i, 4'd1) : '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if ({bus.in_valid, bus.in, bus.s_ready, bus.fifo_count} !== {1'b0, sample_t'(0), 1'b1, 4'd0}) begin
            n_err++; $display("FAIL async_reset_bus: got v=%0b in=%0d rdy=%0b cnt=%0d want 0/0/1/0", bus.in_valid, bus.in, bus.s_ready, bus.fifo_count);
        end
        n_vec++; if ({underrun, underrun_cnt, served_cnt} !== 49'd0) begin
            n_err++; $display("FAIL async_reset_counters: got und=%0b uc=%0d sc=%0d want 0", underrun, underrun_cnt, served_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int pushed;
        logic v;
        logic acc;
        pushed = 0;
        for (int t = 0; t < 1100 && m_served < 1000; t++) begin
            v   = (pushed < 1000);
            acc = v && (q.size() < DEPTH_T);
            step(v, sample_t'(pushed), (t >= 2) ? core_req($urandom_range(0, N_CORES-1), REQ_W'($urandom_range(1, 15))) : '0, 1'b0);
            if (acc) pushed++;
            if (t >= 1 && m_served < 1000) begin
                n_vec++; if ({bus.in_valid, bus.in} !== {1'b1, sample_t'(m_served)}) begin
                    n_err++; $display("FAIL b2b_seq t=%0d: got v=%0b in=%0d want v=1 in=%0d", t, bus.in_valid, bus.in, m_served);
                end
            end
        end
        n_vec++; if ({served_cnt, underrun, bus.in_valid, bus.in} !== {32'd1000, 1'b0, 1'b0, sample_t'(999)}) begin
            n_err++; $display("FAIL b2b_final: got sc=%0d und=%0b v=%0b in=%0d want 1000/0/0/999", served_cnt, underrun, bus.in_valid, bus.in);
        end
    endtask

    task automatic test_random();
        logic [RW-1:0] r;
        for (int t = 0; t < 1500; t++) begin
            r = '0;
            if ($urandom_range(0, 99) < 45)
                for (int j = 0; j < $urandom_range(1, 3); j++)
                    r[$urandom_range(0, N_CORES-1)*REQ_W +: REQ_W] = REQ_W'($urandom_range(1, 15));
            step($urandom_range(0, 99) < 55, sample_t'($urandom), r, $urandom_range(0, 49) == 0);
            n_vec++;
            if ({bus.in_valid, bus.in, bus.s_ready, bus.fifo_count, underrun, underrun_cnt, served_cnt} !==
                {m_valid, m_in, (q.size() < DEPTH_T), 4'(q.size()), m_und, m_ucnt, m_served}) begin
                n_err++;
                $display("FAIL rand t=%0d: got v=%0b in=%0d rdy=%0b cnt=%0d und=%0b uc=%0d sc=%0d want v=%0b in=%0d rdy=%0b cnt=%0d und=%0b uc=%0d sc=%0d",
                         t, bus.in_valid, bus.in, bus.s_ready, bus.fifo_count, underrun, underrun_cnt, served_cnt,
                         m_valid, m_in, (q.size() < DEPTH_T), q.size(), m_und, m_ucnt, m_served);
            end
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.req_in  = '0;
        test_reset();
        test_prime();
        test_requests();
        test_underrun();
        test_full();
        test_clr();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_dispatcher.md
# sample_dispatcher

Hardware sample server for the `multicore` array. It accepts the input sample stream from upstream over a valid/ready handshake and buffers it in a small FIFO. It drives the shared `in` bus of all cores and advances to the next sample whenever any core raises its request code. This is the synthesizable responder side of the per-core `req_in` protocol, replacing the file-reading stimulus used in simulation. It also reports underruns and a served-sample count.

## Interface
- `N_CORES`, 30, number of cores whose requests are monitored
- `REQ_W`, 4, width of each core's request field
- `DATA_W`, 19, signed sample width
- `DEPTH`, 8, FIFO depth in samples; power of two, ≥2
- `clk` in 1: the single clock; all logic on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `s_data` in DATA_W: signed upstream sample
- `s_valid` in 1: upstream sample valid
- `s_ready` out 1: dispatcher can accept a sample
- `req_in` in N_CORES*REQ_W: per-core request fields, core k at bits [k*REQ_W +: REQ_W]
- `in` out DATA_W: signed shared sample bus to all cores, registered
- `in_valid` out 1: `in` holds a sample not yet consumed
- `clr` in 1: synchronous clear of the counters and the sticky flag
- `underrun` out 1: sticky; a request arrived while `in_valid`=0
- `underrun_cnt` out 16: saturating count of underrun events
- `served_cnt` out 32: wrapping count of samples consumed by requests

## Operation
- Request detect: `req_any` = OR over cores of (field ≠ 0), sampled at posedge. Simultaneous requests from several cores count as one request and consume one sample.
- Push: `s_valid & s_ready` writes `s_data` into the FIFO. `s_ready` = !full, with no combinational dependence on `s_valid` or a same-cycle pop.
- Dispatch rules, evaluated per cycle in priority order:
  - `req_any` & `in_valid`: the current sample is consumed and `served_cnt`++. If the FIFO is non-empty, load its head into `in`, pop, and keep `in_valid`=1. Otherwise set `in_valid`=0 and hold `in`.
  - `req_any` & !`in_valid`: set `underrun`=1 and increment `underrun_cnt` (saturating at 0xFFFF). No pop occurs this cycle.
  - !`req_any` & !`in_valid` & FIFO non-empty: prime by loading the head into `in`, popping, and setting `in_valid`=1.
  - Otherwise hold all state.
- A push and a pop in the same cycle are legal at any occupancy. On a full FIFO, `s_ready`=0, so a push cannot occur.
- `clr`=1 zeroes `underrun`, `underrun_cnt` and `served_cnt`. It does not touch the FIFO, `in` or `in_valid`. If `clr` and an event occur in the same cycle, `clr` wins.
- Values pass through unmodified. No sign extension or truncation is applied.

## Timing
- Reset values while `rst_n`=0: FIFO empty, `s_ready`=1, `in`=0, `in_valid`=0, `underrun`=0, `underrun_cnt`=0, `served_cnt`=0.
- Reset asserted mid-operation discards buffered samples immediately and asynchronously.
- Latency from upstream accept into an idle dispatcher (FIFO empty, `in_valid`=0) to the sample on `in`: 2 cycles, one to write the FIFO and one to prime.
- With the FIFO non-empty, a request at edge k presents the next sample on `in` after edge k.
- Sustained one request per cycle is supported at full throughput while upstream keeps up.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit or an occupancy counter.

## Structure
- Package `multicore_pkg` holds `DATA_W`, `REQ_W` and `N_CORES` defaults, the `REQ_NONE`=4'd0 constant, and the `sample_t` signed typedef.
- Sub-module `sample_fifo`: synchronous FIFO (DEPTH, DATA_W) with push, pop, head, full, empty and count outputs.
- The top level holds the request reduction, the dispatch logic, the `in` register and the counters.

## Test plan
- Reset, push samples 5, -7, 100, then no requests: `in`=5, `in_valid`=1 two cycles after the first accept, FIFO count=2.
- Core 0 requests, then core 29 requests, then cores 3 and 17 request in the same cycle: `in` steps 5→-7→100, then `in_valid`=0 with `in` holding 100. `served_cnt`=3.
- Request while `in_valid`=0 and the FIFO is empty: `underrun`=1 and `underrun_cnt`=1. A subsequent push of 42 primes `in`=42 without a pop-on-request.
- Push 9 samples with DEPTH=8 and no requests: `s_ready` drops after 8 FIFO entries plus 1 in `in`. It rises the cycle after the first request.
- Request every cycle with `s_valid` held high and values 0..999: `in` tracks the sequence with no gaps and no duplicates. `served_cnt`=1000 and `underrun`=0 once the pipeline is primed.
- Assert `rst_n` low mid-burst, and separately `clr`: all outputs return to reset values. `clr` zeroes only the counters and the flag, and `in` is unchanged.
